// File: rtl/rgb_to_yuv_encoder_if.sv
// rgb_to_yuv_encoder_if: shared SRAM port plus start/status handshake of the RGB->YUV encoder
interface rgb_to_yuv_encoder_if;
  logic        Enable;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Busy;
  logic        Done;
  modport master (
    input  Enable, SRAM_read_data,
    output SRAM_address, SRAM_write_data, SRAM_we_n, Busy, Done
  );
  modport slave (
    output Enable, SRAM_read_data,
    input  SRAM_address, SRAM_write_data, SRAM_we_n, Busy, Done
  );
endinterface

// File: rtl/rgb_to_yuv_encoder.sv
// rgb_to_yuv_encoder: reads interleaved RGB from SRAM, converts to BT.601 YUV, writes planar Y/U/V (UV_AVG_EN selects averaged chroma)
module rgb_to_yuv_encoder #(
  parameter int NUM_PIXELS = 76800,
  parameter int Y_BASE     = 0,
  parameter int U_BASE     = 38400,
  parameter int V_BASE     = 57600,
  parameter int RGB_BASE   = 146944
) (
  input  logic Clock,
  input  logic Resetn,
  rgb_to_yuv_encoder_if.master bus
);
  localparam int NG = NUM_PIXELS / 4;
  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5, S_RD_W0, S_RD_W1,
    S_CONV, S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V, S_DONE
  } state_t;
  state_t state;
  logic [17:0] grp;
  logic [17:0] rd_base;
  logic [1:0] pix;
  logic [1:0] ph;
  logic [95:0] rgb_buf;
  logic [7:0] y_r [4];
  logic [7:0] u_r [4];
  logic [7:0] v_r [4];
  logic [23:0] px;
  logic signed [31:0] cr, cg, cb, off, sum, q;
  logic [7:0] clip;
  logic [15:0] u_word, v_word;
  assign rd_base = 18'(RGB_BASE) + grp * 18'd6;
  // One colour component per cycle: phase 0 = Y, 1 = U, 2 = V of the current pixel
  always_comb begin
    px = pix == 2'd0 ? rgb_buf[95:72] : pix == 2'd1 ? rgb_buf[71:48] : pix == 2'd2 ? rgb_buf[47:24] : rgb_buf[23:0];
    cr = ph == 2'd0 ? 32'sd16843 : ph == 2'd1 ? -32'sd9699 : 32'sd28770;
    cg = ph == 2'd0 ? 32'sd33030 : ph == 2'd1 ? -32'sd19071 : -32'sd24117;
    cb = ph == 2'd0 ? 32'sd6423 : ph == 2'd1 ? 32'sd28770 : -32'sd4653;
    off = ph == 2'd0 ? 32'sd1081344 : 32'sd8421376;
    sum = cr * $signed({24'd0, px[23:16]}) + cg * $signed({24'd0, px[15:8]}) + cb * $signed({24'd0, px[7:0]}) + off;
    q = sum >>> 16;
    clip = q[31] ? 8'd0 : |q[30:8] ? 8'd255 : q[7:0];
  end
`ifdef UV_AVG_EN
  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    return 8'((9'(a) + 9'(b) + 9'd1) >> 1);
  endfunction
  assign u_word = {avg(u_r[0], u_r[1]), avg(u_r[2], u_r[3])};
  assign v_word = {avg(v_r[0], v_r[1]), avg(v_r[2], v_r[3])};
`else
  assign u_word = {u_r[0], u_r[2]};
  assign v_word = {v_r[0], v_r[2]};
`endif
  // Group sequencer: 6 reads, 2 drain cycles, 12 conversion cycles, 4 writes; all bus outputs registered
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
      bus.SRAM_address <= '0;
      bus.SRAM_write_data <= '0;
      bus.SRAM_we_n <= 1'b1;
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
      grp <= '0;
      pix <= '0;
      ph <= '0;
      rgb_buf <= '0;
      for (int i = 0; i < 4; i++) begin
        y_r[i] <= '0;
        u_r[i] <= '0;
        v_r[i] <= '0;
      end
    end else begin
      if (state inside {S_RD2, S_RD3, S_RD4, S_RD5, S_RD_W0, S_RD_W1})
        rgb_buf <= {rgb_buf[79:0], bus.SRAM_read_data};
      case (state)
        S_IDLE: if (bus.Enable) begin
          state <= S_RD0;
          bus.Busy <= 1'b1;
          bus.SRAM_address <= rd_base;
        end
        S_RD0, S_RD1, S_RD2, S_RD3, S_RD4: begin
          state <= state_t'(state + 4'd1);
          bus.SRAM_address <= bus.SRAM_address + 18'd1;
        end
        S_RD5, S_RD_W0: state <= state_t'(state + 4'd1);
        S_RD_W1: begin
          state <= S_CONV;
          pix <= '0;
          ph <= '0;
        end
        S_CONV: begin
          if (ph == 2'd0) y_r[pix] <= clip;
          if (ph == 2'd1) u_r[pix] <= clip;
          if (ph == 2'd2) v_r[pix] <= clip;
          ph <= ph == 2'd2 ? 2'd0 : ph + 2'd1;
          pix <= ph == 2'd2 ? pix + 2'd1 : pix;
          if (pix == 2'd3 && ph == 2'd2) begin
            state <= S_WR_Y0;
            bus.SRAM_address <= 18'(Y_BASE) + {grp[16:0], 1'b0};
            bus.SRAM_write_data <= {y_r[0], y_r[1]};
            bus.SRAM_we_n <= 1'b0;
          end
        end
        S_WR_Y0: begin
          state <= S_WR_Y1;
          bus.SRAM_address <= bus.SRAM_address + 18'd1;
          bus.SRAM_write_data <= {y_r[2], y_r[3]};
        end
        S_WR_Y1: begin
          state <= S_WR_U;
          bus.SRAM_address <= 18'(U_BASE) + grp;
          bus.SRAM_write_data <= u_word;
        end
        S_WR_U: begin
          state <= S_WR_V;
          bus.SRAM_address <= 18'(V_BASE) + grp;
          bus.SRAM_write_data <= v_word;
        end
        S_WR_V: begin
          bus.SRAM_we_n <= 1'b1;
          if (grp == 18'(NG - 1)) begin
            state <= S_DONE;
            bus.Done <= 1'b1;
            bus.Busy <= 1'b0;
            grp <= '0;
          end else begin
            state <= S_RD0;
            grp <= grp + 18'd1;
            bus.SRAM_address <= rd_base + 18'd6;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          bus.Done <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
